// File: rtl/flag_register.sv
// Registered ULA flag capture with sticky Zero/Overflow and a saturating zero-result counter.
// Zero is taken from the binary result or from the seven-segment digit bus.
module flag_register #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  src_sel,
  input  logic [WIDTH-1:0]      result,
  input  logic                  carry_in,
  input  logic                  ovf_in,
  input  logic [7*DIGITS-1:0]   hex_bus,
  input  logic                  clear_sticky,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  sticky_z,
  output logic                  sticky_v,
  output logic [CNT_W-1:0]      zero_count,
  output logic                  flags_valid
);

  // Active-low segments, a = bit 0: a-f lit, g dark shows "0".
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  logic             seg_all_zero;
  logic             z_next;
  logic             n_next;
  logic             sz_base;
  logic             sv_base;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    seg_all_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (hex_bus[7*k +: 7] != SEG_ZERO) seg_all_zero = 1'b0;
    end
  end

  assign z_next = src_sel ? seg_all_zero : (result == '0);
  assign n_next = src_sel ? 1'b0 : result[WIDTH-1];

  // A clear on the same edge as a load wipes the old history before the new load accumulates.
  assign sz_base  = clear_sticky ? 1'b0 : sticky_z;
  assign sv_base  = clear_sticky ? 1'b0 : sticky_v;
  assign cnt_base = clear_sticky ? '0 : zero_count;

  always_comb begin
    cnt_next = cnt_base;
    if (z_next && (cnt_base != {CNT_W{1'b1}})) cnt_next = cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
      sticky_z    <= 1'b0;
      sticky_v    <= 1'b0;
      zero_count  <= '0;
      flags_valid <= 1'b0;
    end else if (load) begin
      flag_z      <= z_next;
      flag_n      <= n_next;
      flag_c      <= carry_in;
      flag_v      <= ovf_in;
      sticky_z    <= sz_base | z_next;
      sticky_v    <= sv_base | ovf_in;
      zero_count  <= cnt_next;
      flags_valid <= 1'b1;
    end else if (clear_sticky) begin
      sticky_z    <= 1'b0;
      sticky_v    <= 1'b0;
      zero_count  <= '0;
    end
  end

endmodule
